avalon_reg_master: RTL
======================

// Module: avalon_reg_master
// PURPOSE
//  Bus initiator for the chip-select/read/write register-slave interface used by our register blocks.
//  Accepts single read or write commands on a valid/ready port and runs one bus transaction per command.
//  Bus signals: active-low CS/WR/RD, address, write data, read data.
//  Returns one response per command. Sits between a test/control engine and one slave.
// PARAMETERS
//  ADDR_W       1   bus address width
//  DATA_W       32  bus data width
//  WAIT_STATES  0   extra strobe cycles; strobe is low WAIT_STATES+1 cycles (0..15)
//  READ_LATENCY 1   cycles from end of read strobe to valid slave iData (0..7)
// PORTS
//  iclk          in   1       clock, all logic on rising edge
//  ireset        in   1       synchronous reset, active-high
//  iCmdValid     in   1       command present
//  oCmdReady     out  1       command accepted when iCmdValid & oCmdReady
//  iCmdWrite     in   1       1 = write, 0 = read
//  iCmdAddr      in   ADDR_W  target address
//  iCmdData      in   DATA_W  write data (ignored for reads)
//  oRspValid     out  1       one-cycle response pulse, no backpressure
//  oRspWrite     out  1       type of completed command
//  oRspData      out  DATA_W  read data; 0 for writes
//  oBusy         out  1       high in every state except IDLE
//  oChipSelect_n out  1       slave select, active-low
//  oWrite_n      out  1       write strobe, active-low
//  oRead_n       out  1       read strobe, active-low
//  oAddress      out  ADDR_W  bus address
//  oData         out  DATA_W  bus write data
//  iData         in   DATA_W  bus read data from slave
// BEHAVIOUR
//  Reset (sync): state=IDLE; CS_n/WR_n/RD_n=1; oAddress=0; oData=0; oRspValid=0; oRspWrite=0;
//    oRspData=0; oCmdReady=1; oBusy=0. All bus outputs are registered.
//  FSM: IDLE -> SETUP -> ACCESS -> [HOLD] -> RESP -> IDLE.
//  IDLE: oCmdReady=1. On handshake in cycle n, latch write/addr/data.
//  SETUP (cycle n+1): CS_n=0; address and, for writes, data driven; strobes high.
//  ACCESS (cycles n+2 .. n+2+WS): CS_n=0; WR_n or RD_n low; addr/data held stable.
//  Write: RESP in cycle n+3+WS; CS_n=1; oRspValid=1, oRspWrite=1, oRspData=0.
//  Read: HOLD for READ_LATENCY cycles with CS_n=0 and strobes high; RL=0 skips HOLD.
//    iData is sampled on the edge ending cycle n+2+WS+RL.
//    RESP in cycle n+3+WS+RL; oRspData is the sampled value and holds until the next response.
//  oCmdReady=0 in all states except IDLE. Earliest next handshake is the cycle after RESP.
//  iCmdValid outside IDLE is ignored; the requester holds the command until ready.
//  RD_n and WR_n are never low together. Strobes are low only while CS_n=0.
//  Wait and latency counters are 4-bit down-counters, loaded on state entry, with no wrap.
//  ireset mid-transaction: the next edge forces all reset values; the latched command is
//    dropped; no oRspValid for it.
//  ireset takes priority over a same-cycle handshake; that command is not accepted.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, SETUP, ACCESS, HOLD, RESP) and the CMD_READ/CMD_WRITE constants.
//  Single module with no sub-modules. The counter is inline.
// TESTING (DATA_W=32, WS=0, RL=1 unless stated)
//  1 Hold ireset=1 for 2 cycles -> CS_n=WR_n=RD_n=1, oCmdReady=1, oRspValid=0, oBusy=0.
//  2 Write addr=1, data=0xDEADBEEF at cycle n -> n+1: CS_n=0, oAddress=1, oData=0xDEADBEEF;
//    n+2: WR_n=0 for exactly 1 cycle; n+3: oRspValid=1, oRspWrite=1.
//  3 Read addr=0, slave returns 0x12345678 one cycle after RD_n is low -> RD_n low 1 cycle;
//    n+4: oRspValid=1, oRspData=0x12345678.
//  4 WS=2, RL=0: write -> WR_n low 3 cycles (n+2..n+4); oRspValid at n+5.
//  5 iCmdValid held high with two queued commands -> second handshake only in the IDLE cycle
//    after RESP; no strobe overlap; exactly one oRspValid per command.
//  6 ireset pulsed during ACCESS of a read -> next cycle CS_n=RD_n=1, oCmdReady=1;
//    no oRspValid for the aborted read.

Source files
------------

// File: rtl/avalon_reg_master_pkg.sv
// Shared definitions for the chip-select/read/write register bus initiator:
// FSM state encoding, command type constants and counter width.
package avalon_reg_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/avalon_reg_master.sv
// Single-command register bus initiator: one CS/WR/RD transaction per accepted
// command, one response pulse per transaction. All outputs come straight from flops.
module avalon_reg_master
    import avalon_reg_master_pkg::*;
#(
    parameter int ADDR_W       = 1,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iCmdValid,
    output logic              oCmdReady,
    input  logic              iCmdWrite,
    input  logic [ADDR_W-1:0] iCmdAddr,
    input  logic [DATA_W-1:0] iCmdData,
    output logic              oRspValid,
    output logic              oRspWrite,
    output logic [DATA_W-1:0] oRspData,
    output logic              oBusy,
    output logic              oChipSelect_n,
    output logic              oWrite_n,
    output logic              oRead_n,
    output logic [ADDR_W-1:0] oAddress,
    output logic [DATA_W-1:0] oData,
    input  logic [DATA_W-1:0] iData,
    output logic [2:0]        oDbgState
);

    // Command port: a command transfers on a rising edge where iCmdValid and
    // oCmdReady are both high. oCmdReady is high only in IDLE; the requester must
    // hold the command stable until it transfers. Responses are single-cycle
    // oRspValid pulses with no backpressure.

    localparam logic [CNT_W-1:0] WS_LOAD   = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             cmd_write_q;
    logic             handshake;

    assign handshake = iCmdValid && oCmdReady;
    assign oDbgState = state;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_n = ST_ACCESS;
                cnt_n   = WS_LOAD;
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (cmd_write_q == CMD_WRITE || READ_LATENCY == 0) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_HOLD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Bus and status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cmd_write_q   <= CMD_READ;
            oChipSelect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= '0;
            oData         <= '0;
            oRspValid     <= 1'b0;
            oRspWrite     <= 1'b0;
            oRspData      <= '0;
            oCmdReady     <= 1'b1;
            oBusy         <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == ST_IDLE && handshake) begin
                cmd_write_q <= iCmdWrite;
                oAddress    <= iCmdAddr;
                oData       <= (iCmdWrite == CMD_WRITE) ? iCmdData : '0;
            end
            oChipSelect_n <= !(state_n == ST_SETUP || state_n == ST_ACCESS || state_n == ST_HOLD);
            oWrite_n      <= !(state_n == ST_ACCESS && cmd_write_q == CMD_WRITE);
            oRead_n       <= !(state_n == ST_ACCESS && cmd_write_q == CMD_READ);
            oRspValid     <= (state_n == ST_RESP);
            oCmdReady     <= (state_n == ST_IDLE);
            oBusy         <= (state_n != ST_IDLE);
            // iData is captured on the edge that enters RESP; the value then holds.
            if (state_n == ST_RESP) begin
                oRspWrite <= cmd_write_q;
                oRspData  <= (cmd_write_q == CMD_WRITE) ? '0 : iData;
            end
        end
    end

endmodule
